apb_slave_responder: RTL and testbench

APB_SLAVE_RESPONDER -- requirements
Module: apb_slave_responder

---
 rtl/apb_slv_pkg.sv | 17 +
 rtl/apb_slv_regfile.sv | 40 ++++
 rtl/apb_slave_responder.sv | 164 ++++++++++++++++
 tb/tb_apb_slave_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB slave responder and its register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_slv_pkg;

   // Transfer sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } state_e;

   localparam int          NUM_REGS          = 16;
   localparam int          IDX_W             = 4;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/apb_slv_regfile.sv
// 16 x 32-bit register storage: one synchronous write port, one read port.
// Latency: write lands at the clock edge; read is combinational from the array.
// Backpressure: none, a write is accepted in any cycle; clr overrides a write.
module apb_slv_regfile
   import apb_slv_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [NUM_REGS];
   logic [31:0] mem_d [NUM_REGS];

   // Next array contents: the addressed entry takes wdata when we is high.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage flops with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_responder.sv
// APB slave with a 64-byte window of 16 registers and programmable wait states.
// Latency: Pready/Prdata registered; Wait_cycles=0 gives 2-cycle transfers, N>0 gives N+2.
// Backpressure: Wait_cycles stalls Pready; APB_SLV_PSLVERR_EN makes misses raise Pslverr.
module apb_slave_responder
   import apb_slv_pkg::*;
#(
   parameter int          SEL_BIT   = 0,
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   input  logic [3:0]  Wait_cycles,
   output logic [31:0] Prdata,
   output logic        Pready,
   output logic        Pslverr
);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             hit_q, hit_d;
   logic             wr_q, wr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      prdata_q, prdata_d;
   logic             pready_q, pready_d;
   logic             pslverr_q, pslverr_d;

   logic             sel;
   logic             a_hit;
   logic [IDX_W-1:0] a_idx;
   logic             load_resp;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_hit;
   logic             rd_wr;
   logic             rf_we;
   logic [31:0]      rf_rdata;
   logic             unused_in;

   assign sel   = Pselx[SEL_BIT];
   assign a_hit = (Paddr[31:6] == BASE_ADDR[31:6]);
   assign a_idx = Paddr[5:2];

   // Byte-lane bits and the other slaves' selects are deliberately ignored.
   assign unused_in = ^{Pselx, Paddr[1:0]};

   // The captured write commits during the single READY cycle; misses are dropped.
   assign rf_we = (state_q == ST_READY) && wr_q && hit_q;

   apb_slv_regfile u_regfile (
      .clk   (Hclk),
      .clr   (Hreset),
      .we    (rf_we),
      .waddr (idx_q),
      .wdata (wdata_q),
      .raddr (rd_idx),
      .rdata (rf_rdata)
   );

   // Next-state, capture and response logic; the response is loaded on the edge entering READY.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      hit_d     = hit_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      prdata_d  = prdata_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      load_resp = 1'b0;
      rd_idx    = idx_q;
      rd_hit    = hit_q;
      rd_wr     = wr_q;

      case (state_q)
         ST_IDLE: begin
            // Only a genuine setup phase starts a transfer; a lone Penable is ignored.
            if (sel && !Penable) begin
               idx_d   = a_idx;
               hit_d   = a_hit;
               wr_d    = Pwrite;
               wdata_d = Pwdata;
               cnt_d   = Wait_cycles;
               if (Wait_cycles == 4'd0) begin
                  // Zero-wait: respond straight from the live setup-phase address.
                  state_d   = ST_READY;
                  load_resp = 1'b1;
                  rd_idx    = a_idx;
                  rd_hit    = a_hit;
                  rd_wr     = Pwrite;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (sel && Penable) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d   = ST_READY;
                  load_resp = 1'b1;
               end
            end else begin
               // Master abandoned the access: drop it without touching storage.
               state_d = ST_IDLE;
            end
         end
         ST_READY: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_resp) begin
         pready_d = 1'b1;
         // Writes leave Prdata holding its last read value.
         if (!rd_wr) begin
            prdata_d = rd_hit ? rf_rdata : 32'h0;
         end
`ifdef APB_SLV_PSLVERR_EN
         pslverr_d = !rd_hit;
`else
         pslverr_d = 1'b0;
`endif
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         hit_q     <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         hit_q     <= hit_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign Prdata  = prdata_q;
   assign Pready  = pready_q;
   assign Pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_responder.sv
// Directed bench for apb_slave_responder: vector table plus reset/abort/idle sequences.
// Latency: checks access-cycle counts of 1 (zero wait) or Wait_cycles+1.
// Backpressure: every Pready wait is bounded; an expired bound counts as an error.
module tb_apb_slave_responder;

`ifdef APB_SLV_PSLVERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic        Hclk;
   logic        Hreset;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [3:0]  Wait_cycles;
   logic [31:0] Prdata;
   logic        Pready;
   logic        Pslverr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  waits;
      logic [3:0]  waits_acc;
      logic [31:0] exp_rd;
      logic        miss;
      int          exp_acc;
   } vec_t;

   vec_t vecs [12];

   apb_slave_responder dut (
      .Hclk        (Hclk),
      .Hreset      (Hreset),
      .Pselx       (Pselx),
      .Penable     (Penable),
      .Pwrite      (Pwrite),
      .Paddr       (Paddr),
      .Pwdata      (Pwdata),
      .Wait_cycles (Wait_cycles),
      .Prdata      (Prdata),
      .Pready      (Pready),
      .Pslverr     (Pslverr)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   // Free-running cycle counter for transfer-length measurement.
   always @(posedge Hclk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic go_idle();
      Pselx   = 3'b000;
      Penable = 1'b0;
   endtask

   // One full APB transfer; returns at the start of the cycle after the Pready cycle.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] waits, input logic [3:0] waits_acc,
                       input logic [31:0] exp_rd, input logic miss, input int exp_acc,
                       input string name);
      int   n;
      logic done;
      Pselx       = 3'b001;
      Penable     = 1'b0;
      Pwrite      = wr;
      Paddr       = addr;
      Pwdata      = data;
      Wait_cycles = waits;
      chk({name, " setup_pready"}, 32'(Pready), 32'h0);
      tick();
      Penable     = 1'b1;
      Wait_cycles = waits_acc;
      n    = 1;
      done = 1'b0;
      while (!done && n <= 20) begin
         if (Pready) begin
            done = 1'b1;
         end else begin
            tick();
            n++;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no Pready within 20 access cycles", name);
      end else begin
         chk({name, " access_cycles"}, 32'(n), 32'(exp_acc));
         chk({name, " prdata"}, Prdata, exp_rd);
         chk({name, " pslverr"}, 32'(Pslverr), 32'(miss & ERR_EN));
      end
      tick();
   endtask

   initial begin
      int c0;

      //        wr    addr          data          w     wacc  exp_rd        miss  acc
      vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'd0, 4'd0,  32'h0000_0000, 1'b0, 1};
      vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'd0, 4'd0,  32'hDEAD_BEEF, 1'b0, 1};
      vecs[2]  = '{1'b0, 32'h8000_0010, 32'h0,         4'd3, 4'd3,  32'hDEAD_BEEF, 1'b0, 4};
      vecs[3]  = '{1'b1, 32'h9000_0000, 32'h1234_5678, 4'd0, 4'd0,  32'hDEAD_BEEF, 1'b1, 1};
      vecs[4]  = '{1'b0, 32'h9000_0000, 32'h0,         4'd0, 4'd0,  32'h0000_0000, 1'b1, 1};
      vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0,         4'd0, 4'd0,  32'h0000_0000, 1'b0, 1};
      vecs[6]  = '{1'b0, 32'h8000_0010, 32'h0,         4'd0, 4'd0,  32'hDEAD_BEEF, 1'b0, 1};
      vecs[7]  = '{1'b1, 32'h8000_0013, 32'h0000_00AA, 4'd1, 4'd1,  32'hDEAD_BEEF, 1'b0, 2};
      vecs[8]  = '{1'b0, 32'h8000_0010, 32'h0,         4'd1, 4'd15, 32'h0000_00AA, 1'b0, 2};
      vecs[9]  = '{1'b1, 32'h8000_003C, 32'h5555_0000, 4'd2, 4'd0,  32'h0000_00AA, 1'b0, 3};
      vecs[10] = '{1'b0, 32'h8000_003C, 32'h0,         4'd0, 4'd0,  32'h5555_0000, 1'b0, 1};
      vecs[11] = '{1'b0, 32'h8000_0040, 32'h0,         4'd0, 4'd0,  32'h0000_0000, 1'b1, 1};

      Hreset      = 1'b1;
      Pselx       = 3'b000;
      Penable     = 1'b0;
      Pwrite      = 1'b0;
      Paddr       = 32'h0;
      Pwdata      = 32'h0;
      Wait_cycles = 4'd0;
      repeat (3) tick();
      chk("reset prdata", Prdata, 32'h0);
      chk("reset pready", 32'(Pready), 32'h0);
      chk("reset pslverr", 32'(Pslverr), 32'h0);
      Hreset = 1'b0;

      // Directed vector table, applied back to back.
      for (int i = 0; i < 12; i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].waits, vecs[i].waits_acc,
              vecs[i].exp_rd, vecs[i].miss, vecs[i].exp_acc, $sformatf("vec%0d", i));
      end

      // Back-to-back: 16 writes then 16 reads, no idle cycles, 2 cycles each.
      c0 = cyc;
      for (int i = 0; i < 16; i++) begin
         xfer(1'b1, 32'h8000_0000 + 32'(i * 4), 32'(i), 4'd0, 4'd0, 32'h0, 1'b0, 1,
              $sformatf("b2b_wr%0d", i));
      end
      for (int i = 0; i < 16; i++) begin
         xfer(1'b0, 32'h8000_0000 + 32'(i * 4), 32'h0, 4'd0, 4'd0, 32'(i), 1'b0, 1,
              $sformatf("b2b_rd%0d", i));
      end
      chk("b2b total_cycles", 32'(cyc - c0), 32'd64);

      // Reset asserted while a write to idx 2 is waiting.
      Pselx       = 3'b001;
      Penable     = 1'b0;
      Pwrite      = 1'b1;
      Paddr       = 32'h8000_0008;
      Pwdata      = 32'hA5A5_A5A5;
      Wait_cycles = 4'd5;
      tick();
      Penable = 1'b1;
      tick();
      tick();
      Hreset = 1'b1;
      go_idle();
      tick();
      chk("midreset prdata", Prdata, 32'h0);
      chk("midreset pready", 32'(Pready), 32'h0);
      chk("midreset pslverr", 32'(Pslverr), 32'h0);
      tick();
      Hreset = 1'b0;
      xfer(1'b0, 32'h8000_0008, 32'h0, 4'd0, 4'd0, 32'h0, 1'b0, 1, "postreset idx2");
      xfer(1'b0, 32'h8000_003C, 32'h0, 4'd0, 4'd0, 32'h0, 1'b0, 1, "postreset idx15");

      // Abort: select dropped while waiting; no update, back in IDLE.
      Pselx       = 3'b001;
      Penable     = 1'b0;
      Pwrite      = 1'b1;
      Paddr       = 32'h8000_0008;
      Pwdata      = 32'h0000_0077;
      Wait_cycles = 4'd3;
      tick();
      Penable = 1'b1;
      tick();
      go_idle();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("abort pready%0d", k), 32'(Pready), 32'h0);
      end
      xfer(1'b0, 32'h8000_0008, 32'h0, 4'd0, 4'd0, 32'h0, 1'b0, 1, "after_abort idx2");

      // Penable without a setup phase, then a transfer addressed to another slave.
      Pselx   = 3'b001;
      Penable = 1'b1;
      Pwrite  = 1'b0;
      Paddr   = 32'h8000_0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("stray_enable pready%0d", k), 32'(Pready), 32'h0);
      end
      go_idle();
      tick();
      Pselx   = 3'b010;
      Penable = 1'b0;
      tick();
      Penable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("other_slave pready%0d", k), 32'(Pready), 32'h0);
      end
      go_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
